// File: rtl/wdt_pkg.sv
// Watchdog supervisor shared types: FSM state encoding and default timing constants
// derived from the 12 MHz system clock.
package wdt_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StArmed    = 3'd1,
      StShutdown = 3'd2,
      StRecover  = 3'd3,
      StLockout  = 3'd4
   } wdt_state_e;

   localparam int unsigned ClkHz         = 12_000_000;
   localparam int unsigned DefTimeoutCyc = ClkHz / 8;          // 125 ms
   localparam int unsigned DefWarnCyc    = DefTimeoutCyc / 2;
   localparam int unsigned DefHoldCyc    = ClkHz / 1000;       // 1 ms
   localparam int unsigned DefMaxRetry   = 3;
   localparam int unsigned DefCntW       = 21;

endpackage

// File: rtl/wdt_src_timer.sv
// One heartbeat source: 2-FF synchronizer, rising-edge kick detector and a
// saturating silence counter that reports timeout and warn thresholds.
module wdt_src_timer
   import wdt_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
   parameter int unsigned WARN_CYC    = DefWarnCyc,
   parameter int unsigned CNT_W       = DefCntW
) (
   input  logic const_clk,
   input  logic rst_n,
   input  logic hb_in,
   input  logic mask,
   input  logic run,
   output logic timeout,
   output logic warn_hit
);

   logic [1:0]       sync_q;
   logic             hb_prev_q;
   logic             kick;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge const_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= '0;
         hb_prev_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], hb_in};
         hb_prev_q <= sync_q[1];
      end
   end

   assign kick = sync_q[1] & ~hb_prev_q;

   always_ff @(posedge const_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!run || mask || kick) begin
         cnt_q <= '0;
      end else if (cnt_q != CNT_W'(TIMEOUT_CYC)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // A kick landing on the saturated count rescues the source.
   assign timeout  = ~mask & ~kick & (cnt_q == CNT_W'(TIMEOUT_CYC));
   assign warn_hit = ~mask & (cnt_q >= CNT_W'(WARN_CYC));

endmodule

// File: rtl/watchdog_supervisor.sv
// Multi-source watchdog: arms on enable, warns and shuts down on heartbeat loss,
// performs timed restarts and locks out after repeated failures.
module watchdog_supervisor
   import wdt_pkg::*;
#(
   parameter int unsigned N_SRC       = 2,
   parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
   parameter int unsigned WARN_CYC    = DefWarnCyc,
   parameter int unsigned HOLD_CYC    = DefHoldCyc,
   parameter int unsigned MAX_RETRY   = DefMaxRetry,
   parameter int unsigned CNT_W       = DefCntW
) (
   input  logic             const_clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [N_SRC-1:0] hb_in,
   input  logic [N_SRC-1:0] src_mask,
   output logic             shutdown,
   output logic             warn,
   output logic             restart_req,
   output logic             lockout,
   output logic [N_SRC-1:0] fault_src,
   output logic [1:0]       retry_cnt,
   output logic [2:0]       state
);

   wdt_state_e       state_q;
   logic [CNT_W-1:0] hold_cnt_q;
   logic             shutdown_q;
   logic             warn_q;
   logic             restart_req_q;
   logic             lockout_q;
   logic [N_SRC-1:0] fault_src_q;
   logic [1:0]       retry_cnt_q;
   logic [N_SRC-1:0] timeout_vec;
   logic [N_SRC-1:0] warn_vec;
   logic             run;

   // Source counters only run while armed, so every re-arm gets a full grace period.
   assign run = (state_q == StArmed);

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      wdt_src_timer #(
         .TIMEOUT_CYC (TIMEOUT_CYC),
         .WARN_CYC    (WARN_CYC),
         .CNT_W       (CNT_W)
      ) u_timer (
         .const_clk (const_clk),
         .rst_n     (rst_n),
         .hb_in     (hb_in[i]),
         .mask      (src_mask[i]),
         .run       (run),
         .timeout   (timeout_vec[i]),
         .warn_hit  (warn_vec[i])
      );
   end

   always_ff @(posedge const_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         hold_cnt_q    <= '0;
         shutdown_q    <= 1'b0;
         warn_q        <= 1'b0;
         restart_req_q <= 1'b0;
         lockout_q     <= 1'b0;
         fault_src_q   <= '0;
         retry_cnt_q   <= '0;
      end else begin
         restart_req_q <= 1'b0;
         warn_q        <= 1'b0;
         unique case (state_q)
            StIdle: begin
               retry_cnt_q <= '0;
               if (enable) begin
                  state_q <= StArmed;
               end
            end
            StArmed: begin
               if (|timeout_vec) begin
                  state_q     <= StShutdown;
                  shutdown_q  <= 1'b1;
                  fault_src_q <= timeout_vec;
                  hold_cnt_q  <= '0;
               end else if (!enable) begin
                  state_q     <= StIdle;
                  retry_cnt_q <= '0;
               end else begin
                  warn_q <= |warn_vec;
               end
            end
            StShutdown: begin
               if (hold_cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                  if ({30'd0, retry_cnt_q} < MAX_RETRY) begin
                     state_q       <= StRecover;
                     shutdown_q    <= 1'b0;
                     restart_req_q <= 1'b1;
                     if (retry_cnt_q != 2'd3) begin
                        retry_cnt_q <= retry_cnt_q + 2'd1;
                     end
                  end else begin
                     state_q   <= StLockout;
                     lockout_q <= 1'b1;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q + CNT_W'(1);
               end
            end
            StRecover: begin
               if (!enable) begin
                  state_q     <= StIdle;
                  retry_cnt_q <= '0;
               end else begin
                  state_q <= StArmed;
               end
            end
            StLockout: begin
               state_q <= StLockout;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign shutdown    = shutdown_q;
   assign warn        = warn_q;
   assign restart_req = restart_req_q;
   assign lockout     = lockout_q;
   assign fault_src   = fault_src_q;
   assign retry_cnt   = retry_cnt_q;
   assign state       = state_q;

endmodule

// File: tb/tb_watchdog_supervisor.sv
// Directed bench for watchdog_supervisor with short timing parameters; each check is
// an immediate assertion against a hand-computed value.
module tb_watchdog_supervisor;

   logic       const_clk;
   logic       rst_n;
   logic       enable;
   logic [1:0] hb_in;
   logic [1:0] src_mask;
   logic       shutdown;
   logic       warn;
   logic       restart_req;
   logic       lockout;
   logic [1:0] fault_src;
   logic [1:0] retry_cnt;
   logic [2:0] state;

   int         vectors;
   int         miscompares;
   logic [1:0] hb_on;
   int         phase [2];

   watchdog_supervisor #(
      .N_SRC       (2),
      .TIMEOUT_CYC (100),
      .WARN_CYC    (50),
      .HOLD_CYC    (10),
      .MAX_RETRY   (2),
      .CNT_W       (8)
   ) dut (
      .const_clk   (const_clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .hb_in       (hb_in),
      .src_mask    (src_mask),
      .shutdown    (shutdown),
      .warn        (warn),
      .restart_req (restart_req),
      .lockout     (lockout),
      .fault_src   (fault_src),
      .retry_cnt   (retry_cnt),
      .state       (state)
   );

   initial const_clk = 1'b0;
   always #5 const_clk = ~const_clk;

   initial begin
      #1_000_000;
      $display("FAIL sim_timeout: run did not finish within the time limit");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n negedges; sources with hb_on set produce a rising edge every 40 cycles.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge const_clk);
         for (int s = 0; s < 2; s++) begin
            if (hb_on[s]) begin
               phase[s]++;
               if (phase[s] == 20) begin
                  phase[s] = 0;
                  hb_in[s] = ~hb_in[s];
               end
            end
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_shutdown"}, 32'(shutdown), 32'd0);
      chk({tag, "_warn"}, 32'(warn), 32'd0);
      chk({tag, "_restart"}, 32'(restart_req), 32'd0);
      chk({tag, "_lockout"}, 32'(lockout), 32'd0);
      chk({tag, "_fault"}, 32'(fault_src), 32'd0);
      chk({tag, "_retry"}, 32'(retry_cnt), 32'd0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      enable = 1'b0;
      hb_in = 2'b00;
      src_mask = 2'b00;
      hb_on = 2'b00;
      phase[0] = 0;
      phase[1] = 0;
      cyc(3);
      chk_all_zero("reset");
      rst_n = 1'b1;
      cyc(2);
      chk("idle_no_enable", 32'(state), 32'd0);

      // Healthy run
      enable = 1'b1;
      hb_on = 2'b11;
      cyc(1);
      chk("arm", 32'(state), 32'd1);
      for (int i = 0; i < 20; i++) begin
         cyc(50);
         chk("healthy_state", 32'(state), 32'd1);
         chk("healthy_warn", 32'(warn), 32'd0);
         chk("healthy_shutdown", 32'(shutdown), 32'd0);
      end

      // Warn then recover on src1
      hb_on[1] = 1'b0;
      hb_in[1] = 1'b0;
      cyc(4);
      hb_in[1] = 1'b1;
      cyc(53);
      chk("warn_before", 32'(warn), 32'd0);
      cyc(1);
      chk("warn_set", 32'(warn), 32'd1);
      hb_in[1] = 1'b0;
      cyc(16);
      hb_in[1] = 1'b1;
      cyc(3);
      chk("warn_still", 32'(warn), 32'd1);
      cyc(1);
      chk("warn_clear", 32'(warn), 32'd0);
      chk("warn_no_shutdown", 32'(shutdown), 32'd0);
      chk("warn_state", 32'(state), 32'd1);
      phase[1] = 0;
      hb_on[1] = 1'b1;

      // Timeout and restart on src0
      hb_on[0] = 1'b0;
      hb_in[0] = 1'b0;
      cyc(4);
      hb_in[0] = 1'b1;
      cyc(103);
      chk("to_pre_state", 32'(state), 32'd1);
      chk("to_pre_shutdown", 32'(shutdown), 32'd0);
      chk("to_pre_warn", 32'(warn), 32'd1);
      cyc(1);
      chk("to_state", 32'(state), 32'd2);
      chk("to_shutdown", 32'(shutdown), 32'd1);
      chk("to_fault", 32'(fault_src), 32'h1);
      chk("to_warn_off", 32'(warn), 32'd0);
      cyc(9);
      chk("hold_last_state", 32'(state), 32'd2);
      chk("hold_last_shutdown", 32'(shutdown), 32'd1);
      cyc(1);
      chk("rec1_state", 32'(state), 32'd3);
      chk("rec1_restart", 32'(restart_req), 32'd1);
      chk("rec1_shutdown", 32'(shutdown), 32'd0);
      chk("rec1_retry", 32'(retry_cnt), 32'd1);
      cyc(1);
      chk("rearm1_state", 32'(state), 32'd1);
      chk("rearm1_restart", 32'(restart_req), 32'd0);

      // Lockout with src0 kept dead
      cyc(100);
      chk("grace2_state", 32'(state), 32'd1);
      chk("grace2_shutdown", 32'(shutdown), 32'd0);
      cyc(1);
      chk("to2_state", 32'(state), 32'd2);
      cyc(10);
      chk("rec2_state", 32'(state), 32'd3);
      chk("rec2_restart", 32'(restart_req), 32'd1);
      chk("rec2_retry", 32'(retry_cnt), 32'd2);
      cyc(1);
      chk("rearm2_state", 32'(state), 32'd1);
      cyc(101);
      chk("to3_state", 32'(state), 32'd2);
      chk("to3_shutdown", 32'(shutdown), 32'd1);
      cyc(10);
      chk("lock_state", 32'(state), 32'd4);
      chk("lock_lockout", 32'(lockout), 32'd1);
      chk("lock_shutdown", 32'(shutdown), 32'd1);
      chk("lock_retry", 32'(retry_cnt), 32'd2);
      chk("lock_fault", 32'(fault_src), 32'h1);
      enable = 1'b0;
      cyc(20);
      chk("lock_sticky_state", 32'(state), 32'd4);
      chk("lock_sticky_lockout", 32'(lockout), 32'd1);
      chk("lock_sticky_shutdown", 32'(shutdown), 32'd1);
      hb_on = 2'b00;
      rst_n = 1'b0;
      #1;
      chk_all_zero("lock_reset");
      cyc(2);
      src_mask = 2'b01;
      hb_in = 2'b00;
      rst_n = 1'b1;
      cyc(5);
      chk("post_lock_state", 32'(state), 32'd0);
      chk("post_lock_retry", 32'(retry_cnt), 32'd0);

      // Masked dead src0, kick race on src1, enable drop on the timeout cycle
      enable = 1'b1;
      cyc(5);
      hb_in[1] = 1'b1;
      cyc(50);
      hb_in[1] = 1'b0;
      cyc(10);
      chk("race_warn", 32'(warn), 32'd1);
      cyc(41);
      hb_in[1] = 1'b1;
      cyc(3);
      chk("race_state", 32'(state), 32'd1);
      chk("race_shutdown", 32'(shutdown), 32'd0);
      cyc(20);
      chk("race_after_state", 32'(state), 32'd1);
      chk("race_after_warn", 32'(warn), 32'd0);
      cyc(80);
      chk("en_race_pre_state", 32'(state), 32'd1);
      chk("en_race_pre_shutdown", 32'(shutdown), 32'd0);
      enable = 1'b0;
      cyc(1);
      chk("en_race_state", 32'(state), 32'd2);
      chk("en_race_shutdown", 32'(shutdown), 32'd1);
      chk("en_race_fault", 32'(fault_src), 32'h2);
      cyc(10);
      chk("en_rec_state", 32'(state), 32'd3);
      chk("en_rec_restart", 32'(restart_req), 32'd1);
      chk("en_rec_retry", 32'(retry_cnt), 32'd1);
      cyc(1);
      chk("en_idle_state", 32'(state), 32'd0);
      chk("en_idle_retry", 32'(retry_cnt), 32'd0);

      // All masked, then unmask mid-run and reset during the hold
      src_mask = 2'b11;
      enable = 1'b1;
      cyc(1);
      chk("allmask_arm", 32'(state), 32'd1);
      cyc(200);
      chk("allmask_state", 32'(state), 32'd1);
      chk("allmask_warn", 32'(warn), 32'd0);
      chk("allmask_shutdown", 32'(shutdown), 32'd0);
      src_mask = 2'b00;
      cyc(100);
      chk("unmask_pre_shutdown", 32'(shutdown), 32'd0);
      chk("unmask_pre_warn", 32'(warn), 32'd1);
      cyc(1);
      chk("unmask_state", 32'(state), 32'd2);
      chk("unmask_fault", 32'(fault_src), 32'h3);
      cyc(4);
      chk("hold5_shutdown", 32'(shutdown), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("hold_reset");
      enable = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      chk("final_state", 32'(state), 32'd0);
      chk("final_retry", 32'(retry_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/watchdog_supervisor.md
Name: watchdog_supervisor

Overview:
Multi-source watchdog controller on the 12 MHz system clock domain. It monitors N asynchronous heartbeat (kick) inputs, such as the 1 kHz subsystem clock. It sequences the system through warn, shutdown, timed restart and permanent lockout after repeated failures. It sits between the heartbeat-producing subsystems and the power/reset control that consumes shutdown and restart_req.

Parameters:
N_SRC, 2, number of heartbeat sources
TIMEOUT_CYC, 1500000, const_clk cycles without a rising edge before timeout (125 ms @ 12 MHz)
WARN_CYC, 750000, cycles without an edge before warn asserts; must be < TIMEOUT_CYC
HOLD_CYC, 12000, cycles shutdown is held before a restart attempt (1 ms)
MAX_RETRY, 3, restart attempts allowed before lockout
CNT_W, 21, counter width; must satisfy 2^CNT_W > TIMEOUT_CYC and 2^CNT_W > HOLD_CYC

Ports:
const_clk  in  1  12 MHz system clock, the only clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  arm request (synchronous, level)
hb_in  in  N_SRC  asynchronous heartbeats; rising edge = kick
src_mask  in  N_SRC  1 = source ignored
shutdown  out  1  registered shutdown command
warn  out  1  registered early warning
restart_req  out  1  one-cycle restart pulse
lockout  out  1  retries exhausted
fault_src  out  N_SRC  sources that caused the last timeout
retry_cnt  out  2  restarts since last arm
state  out  3  current FSM state (debug)

Behaviour:
- Reset (async assert, sync release): state=IDLE. shutdown, warn, restart_req, lockout, fault_src, retry_cnt and all counters are 0. The synchronizer flops are 0.
- Per source: 2-FF synchronizer, then a rising-edge detector producing a 1-cycle kick. Kick latency is 3 const_clk cycles from the hb_in edge.
- Per-source counter: cleared on kick, on mask=1, or when state is not ARMED. Otherwise it increments by 1 and saturates at TIMEOUT_CYC. A kick and a counter reaching TIMEOUT_CYC in the same cycle: the kick wins and the counter clears.
- Source timeout: unmasked and counter == TIMEOUT_CYC.
- warn: registered; 1 in ARMED when any unmasked counter >= WARN_CYC; 0 in every other state.
- FSM encoding: IDLE=0, ARMED=1, SHUTDOWN=2, RECOVER=3, LOCKOUT=4.
- IDLE: enable=1 goes to ARMED next cycle. retry_cnt is cleared on entry to IDLE.
- ARMED:
  - enable=0 goes to IDLE.
  - Any source timeout goes to SHUTDOWN; enable=0 in the same cycle is ignored and timeout wins.
  - fault_src latches the timeout vector on that edge and holds it until the next timeout or reset.
- SHUTDOWN:
  - shutdown=1 from the first cycle in the state. The hold counter runs HOLD_CYC cycles; enable is ignored.
  - When the hold ends: retry_cnt < MAX_RETRY goes to RECOVER, otherwise LOCKOUT.
- RECOVER: one cycle only.
  - restart_req=1, shutdown=0, retry_cnt += 1 (saturating at 3).
  - All counters are 0; next state is ARMED, so the system gets a full timeout grace period.
  - If enable=0, go to IDLE instead; restart_req still pulses.
- LOCKOUT: shutdown=1 and lockout=1. Exit only via rst_n.
- All-masked: no timeout is possible; warn stays 0.
- Mask changes mid-count clear that source's counter in the next cycle.
- rst_n asserted in any state returns all outputs to reset values asynchronously.

Decomposition:
- Package wdt_pkg holds:
  - state enum and encodings;
  - default parameter constants (12 MHz-derived TIMEOUT/WARN/HOLD).
- Sub-module wdt_src_timer, instantiated N_SRC times. Per instance:
  - synchronizer and edge detector;
  - saturating counter with clear/mask/run inputs;
  - outputs: timeout and warn_hit.
- Top level holds the FSM, hold counter, retry counter and output registers.

Test Plan (bench params TIMEOUT_CYC=100, WARN_CYC=50, HOLD_CYC=10, MAX_RETRY=2, N_SRC=2):
1. Healthy run: enable=1, both hb_in toggled every 40 cycles for 1000 cycles -> state stays 1, warn=0, shutdown=0.
2. Warn then recover: stop src1 kicks -> warn=1 at 50 cycles after the last kick. Kick src1 at 70 -> warn=0 within 4 cycles, no shutdown.
3. Timeout/restart: stop src0 -> shutdown=1 at the count of 100, fault_src=01. Shutdown is held 10 cycles, then a 1-cycle restart_req, retry_cnt=1, state back to 1.
4. Lockout: keep src0 dead -> second restart leaves retry_cnt=2. Third timeout -> LOCKOUT: lockout=1, shutdown=1, state=4. Deasserting enable has no effect; only rst_n clears it.
5. Masking/races: src_mask=01 with src0 dead -> no timeout. Kick src1 exactly on its 100th count -> no shutdown. Set enable=0 on the timeout cycle -> SHUTDOWN taken.
6. Async reset mid-SHUTDOWN (cycle 5 of hold) -> all outputs 0 immediately; after release the FSM is in IDLE with retry_cnt=0.
